// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Multiplexed N-digit seven-segment scanner with per-digit DP/blank, 16-level PWM and output polarity.
// Optional per-digit blinking (blink_mask port) is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_US     = 1000,
    parameter bit SEL_ACT_LOW = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter int BLINK_MS    = 500
) (
    input  logic                  sclk,
    input  logic                  nrst,
    input  logic [4*DIGITS-1:0]   digit_bus,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [3:0]            bright,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int SCAN_CYC = CLK_HZ / 1_000_000 * SCAN_US;
    localparam int PH_DIV   = SCAN_CYC / 16;
    localparam int SUB_W    = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;

    if (DIGITS < 1 || DIGITS > 16 || SCAN_CYC < 16 || (SCAN_CYC % 16) != 0 || BLINK_MS < 1) begin : g_param_err
        $error("seg_scan_ctrl: illegal parameter set");
    end

    logic [3:0] code_arr [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_code
        assign code_arr[gi] = digit_bus[4*gi +: 4];
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            4'd10:   return 7'h00;
            4'd11:   return 7'h40;
            4'd12:   return 7'h39;
            4'd13:   return 7'h79;
            4'd14:   return 7'h71;
            default: return 7'h73;
        endcase
    endfunction

    logic              run_reg, run_next;
    logic [SUB_W-1:0]  sub_reg, sub_next;
    logic [3:0]        phase_reg, phase_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [3:0]        code_reg, code_next;
    logic              dp_reg, dp_next;
    logic              blank_reg, blank_next;
    logic [3:0]        bright_reg, bright_next;
    logic [DIGITS-1:0] sel_reg, sel_next;
    logic [7:0]        seg_reg, seg_next;
    logic              frame_reg, frame_next;
    logic              slot_tick, load, lit;
    logic [DIGITS-1:0] sel_oh;
    logic [7:0]        seg_pat;

`ifdef SEG_SCAN_BLINK_EN
    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int BL_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_MS - 1);

    logic [MS_W-1:0] ms_reg, ms_next;
    logic [BL_W-1:0] bl_cnt_reg, bl_cnt_next;
    logic            blink_phase_reg, blink_phase_next;
    logic            blink_reg, blink_next;
`endif

    always_comb begin
        run_next    = 1'b1;
        sub_next    = sub_reg;
        phase_next  = phase_reg;
        idx_next    = idx_reg;
        code_next   = code_reg;
        dp_next     = dp_reg;
        blank_next  = blank_reg;
        bright_next = bright_reg;
        sel_oh      = '0;

        slot_tick = run_reg && (phase_reg == 4'd15) && (sub_reg == SUB_LAST);
        // The first clock after reset loads digit 0 as if a slot had just ended.
        load      = !run_reg || slot_tick;

        if (run_reg) begin
            if (sub_reg == SUB_LAST) begin
                sub_next   = '0;
                phase_next = phase_reg + 4'd1;
            end else begin
                sub_next = sub_reg + SUB_W'(1);
            end
        end

        if (load) begin
            if (!run_reg || idx_reg == IDX_LAST)
                idx_next = '0;
            else
                idx_next = idx_reg + IDX_W'(1);
            code_next   = code_arr[idx_next];
            dp_next     = dp_mask[idx_next];
            blank_next  = blank_mask[idx_next];
            bright_next = bright;
        end

        frame_next = slot_tick && (idx_reg == IDX_LAST);
        lit        = (phase_next <= bright_next) && !blank_next;

`ifdef SEG_SCAN_BLINK_EN
        ms_next          = ms_reg + MS_W'(1);
        bl_cnt_next      = bl_cnt_reg;
        blink_phase_next = blink_phase_reg;
        blink_next       = blink_reg;
        if (ms_reg == MS_LAST) begin
            ms_next = '0;
            if (bl_cnt_reg == BL_LAST) begin
                bl_cnt_next      = '0;
                blink_phase_next = !blink_phase_reg;
            end else begin
                bl_cnt_next = bl_cnt_reg + BL_W'(1);
            end
        end
        if (load)
            blink_next = blink_mask[idx_next];
        lit = lit && !(blink_next && blink_phase_next);
`endif

        // Outputs are registered from next-state values so sel and seg switch on the same edge.
        seg_pat          = lit ? {dp_next, seg_decode(code_next)} : 8'h00;
        seg_next         = SEG_ACT_LOW ? ~seg_pat : seg_pat;
        sel_oh[idx_next] = 1'b1;
        sel_next         = SEL_ACT_LOW ? ~sel_oh : sel_oh;
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            run_reg    <= 1'b0;
            sub_reg    <= '0;
            phase_reg  <= '0;
            idx_reg    <= '0;
            code_reg   <= '0;
            dp_reg     <= 1'b0;
            blank_reg  <= 1'b0;
            bright_reg <= '0;
            sel_reg    <= SEL_IDLE;
            seg_reg    <= SEG_IDLE;
            frame_reg  <= 1'b0;
        end else begin
            run_reg    <= run_next;
            sub_reg    <= sub_next;
            phase_reg  <= phase_next;
            idx_reg    <= idx_next;
            code_reg   <= code_next;
            dp_reg     <= dp_next;
            blank_reg  <= blank_next;
            bright_reg <= bright_next;
            sel_reg    <= sel_next;
            seg_reg    <= seg_next;
            frame_reg  <= frame_next;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            ms_reg          <= '0;
            bl_cnt_reg      <= '0;
            blink_phase_reg <= 1'b0;
            blink_reg       <= 1'b0;
        end else begin
            ms_reg          <= ms_next;
            bl_cnt_reg      <= bl_cnt_next;
            blink_phase_reg <= blink_phase_next;
            blink_reg       <= blink_next;
        end
    end
`endif

    assign sel        = sel_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for seg_scan_ctrl: 4 digits, 16-cycle slots, scoreboard of per-cycle sel/seg/frame_tick.
module tb_seg_scan_ctrl;

    logic        sclk = 1'b0;
    logic        nrst;
    logic [15:0] digit_bus;
    logic [3:0]  dp_mask, blank_mask, blink_mask;
    logic [3:0]  bright;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_tick;

    seg_scan_ctrl #(
        .DIGITS(4), .CLK_HZ(1_000_000), .SCAN_US(16),
        .SEL_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b1), .BLINK_MS(1)
    ) dut (
        .sclk(sclk),
        .nrst(nrst),
        .digit_bus(digit_bus),
        .dp_mask(dp_mask),
        .blank_mask(blank_mask),
        .bright(bright),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .sel(sel),
        .seg(seg),
        .frame_tick(frame_tick)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       ft;
        int         slot;
        int         off;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   slot_num = 0;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h40, 7'h39, 7'h79, 7'h71, 7'h73};

    function automatic logic [7:0] model_seg(input logic [3:0] code, input logic dp, input logic blank,
                                             input logic [3:0] br, input int phase, input logic dark);
        logic [7:0] pat;
        pat = {dp, dec_tab[code]};
        if (blank || dark || phase > int'(br))
            pat = 8'h00;
        return ~pat;
    endfunction

    // Queue the expected 16 cycles of the next slot, using the inputs the bench presents at its load edge.
    task automatic plan_slot(input logic [15:0] bus, input logic [3:0] dpm, input logic [3:0] blm,
                             input logic [3:0] br, input logic [3:0] bkm);
        int   d;
        int   edge_n;
        logic dark;
        exp_t e;
        d = slot_num % 4;
        for (int o = 0; o < 16; o++) begin
            edge_n = slot_num * 16 + o + 1;
            dark   = bkm[d] && (((edge_n / 1000) % 2) == 1);
            e.sel  = 4'b0001 << d;
            e.seg  = model_seg(bus[4*d +: 4], dpm[d], blm[d], br, o, dark);
            e.ft   = (o == 0) && (d == 0) && (slot_num > 0);
            e.slot = slot_num;
            e.off  = o;
            sb.push_back(e);
        end
        slot_num++;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk_cnt++;
        if (sel !== 4'b0000) $display("FAIL reset_sel: got %b want 0000", sel); else pass_cnt++;
        chk_cnt++;
        if (seg !== 8'hFF) $display("FAIL reset_seg: got %h want ff", seg); else pass_cnt++;
        chk_cnt++;
        if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick: got %b want 0", frame_tick); else pass_cnt++;
        nrst     = 1'b1;
        slot_num = 0;
    endtask

    task automatic test_scan_order();
        exp_t e;
        for (int s = 0; s < 5; s++) plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < 80; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL scan slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
    endtask

    task automatic test_pwm();
        exp_t e;
        bright = 4'd3;
        for (int s = 0; s < 4; s++) plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < 64; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL pwm slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
    endtask

    task automatic test_masks();
        exp_t e;
        bright     = 4'd15;
        dp_mask    = 4'b0100;
        blank_mask = 4'b1000;
        for (int s = 0; s < 4; s++) plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < 64; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL masks slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
        dp_mask    = 4'b0000;
        blank_mask = 4'b0000;
    endtask

    task automatic test_snapshot();
        exp_t e;
        int   n;
        for (int k = 0; k < 4 && (slot_num % 4) != 1; k++) begin
            plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
            n = 16;
        end
        n = sb.size();
        plan_slot(16'h3210, dp_mask, blank_mask, bright, blink_mask);
        for (int s = 0; s < 3; s++) plan_slot(16'hBBBB, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < n + 64; c++) begin
            if (c == n + 8) digit_bus = 16'hBBBB;
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL snapshot slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
        digit_bus = 16'h3210;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < 5; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL midreset_pre slot=%0d off=%0d: got sel=%b seg=%h want sel=%b seg=%h",
                         e.slot, e.off, sel, seg, e.sel, e.seg);
            else pass_cnt++;
        end
        nrst = 1'b0;
        #1;
        chk_cnt++;
        if ({sel, seg, frame_tick} !== {4'b0000, 8'hFF, 1'b0})
            $display("FAIL midreset_async: got sel=%b seg=%h ft=%b want sel=0000 seg=ff ft=0", sel, seg, frame_tick);
        else pass_cnt++;
        sb.delete();
        @(posedge sclk); @(negedge sclk);
        chk_cnt++;
        if ({sel, seg, frame_tick} !== {4'b0000, 8'hFF, 1'b0})
            $display("FAIL midreset_hold: got sel=%b seg=%h ft=%b want sel=0000 seg=ff ft=0", sel, seg, frame_tick);
        else pass_cnt++;
        nrst     = 1'b1;
        slot_num = 0;
        plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
        for (int c = 0; c < 16; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL midreset_restart slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        exp_t e;
        int   n;
        blink_mask = 4'b0001;
        n = 0;
        while (slot_num < 134) begin
            plan_slot(digit_bus, dp_mask, blank_mask, bright, blink_mask);
            n += 16;
        end
        for (int c = 0; c < n; c++) begin
            @(posedge sclk); @(negedge sclk);
            e = sb.pop_front();
            chk_cnt++;
            if ({sel, seg, frame_tick} !== {e.sel, e.seg, e.ft})
                $display("FAIL blink slot=%0d off=%0d: got sel=%b seg=%h ft=%b want sel=%b seg=%h ft=%b",
                         e.slot, e.off, sel, seg, frame_tick, e.sel, e.seg, e.ft);
            else pass_cnt++;
        end
        blink_mask = 4'b0000;
    endtask
`endif

    initial begin
        nrst       = 1'b0;
        digit_bus  = 16'h3210;
        dp_mask    = 4'b0000;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        bright     = 4'd15;
        @(negedge sclk);
        test_reset();
        test_scan_order();
        test_pwm();
        test_masks();
        test_snapshot();
        test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
